// File: rtl/nibble_sequencer_pkg.sv
// Shared opcode and sequencer-state encodings for the nibble sequencer and the stack core.
package nibble_sequencer_pkg;

   localparam int unsigned SEQ_DEPTH      = 16;
   localparam int unsigned SEQ_AW         = 4;
   localparam int unsigned SEQ_RST_CYCLES = 2;

   typedef enum logic [3:0] {
      OP_NOOP = 4'd0,
      OP_PUSH = 4'd1,
      OP_POP  = 4'd2,
      OP_OUTL = 4'd3,
      OP_OUTH = 4'd4,
      OP_SWAP = 4'd5,
      OP_PUSF = 4'd6,
      OP_REPL = 4'd7,
      OP_BIN  = 4'd8,
      OP_MULT = 4'd9
   } opcode_e;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_CRST,
      SEQ_FETCH,
      SEQ_EXEC,
      SEQ_DONE
   } seq_state_e;

endpackage

// File: rtl/nibble_sequencer_if.sv
// Load port and core-drive bundle between a program source and the sequencer.
// With NIBBLE_SEQ_LOOP_EN defined a loop request line is added.
interface nibble_sequencer_if #(parameter int unsigned AW = 4);
   logic          clear;
   logic          load_valid;
   logic [3:0]    load_data;
   logic          load_ready;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW:0]   prog_len;
   logic          cpu_rst;
   logic [3:0]    cpu_inbits;
`ifdef NIBBLE_SEQ_LOOP_EN
   logic          loop;

   modport master (output clear, load_valid, load_data, start, loop,
                   input  load_ready, busy, done, prog_len, cpu_rst, cpu_inbits);
   modport slave  (input  clear, load_valid, load_data, start, loop,
                   output load_ready, busy, done, prog_len, cpu_rst, cpu_inbits);
`else
   modport master (output clear, load_valid, load_data, start,
                   input  load_ready, busy, done, prog_len, cpu_rst, cpu_inbits);
   modport slave  (input  clear, load_valid, load_data, start,
                   output load_ready, busy, done, prog_len, cpu_rst, cpu_inbits);
`endif
endinterface

// File: rtl/nibble_sequencer_op_timing.sv
// Opcode timing table shared with the core: exec cycles after fetch and operand use.
module nibble_sequencer_op_timing
   import nibble_sequencer_pkg::*;
(
   input  logic [3:0] op_i,
   output logic [1:0] exec_len_o,
   output logic       has_operand_o
);

   always_comb begin
      exec_len_o    = 2'd1;
      has_operand_o = 1'b0;
      case (opcode_e'(op_i))
         OP_PUSH, OP_PUSF, OP_REPL, OP_BIN: begin
            exec_len_o    = 2'd2;
            has_operand_o = 1'b1;
         end
         OP_POP, OP_SWAP: exec_len_o = 2'd2;
         OP_MULT:         exec_len_o = 2'd3;
         default:         exec_len_o = 2'd1;
      endcase
   end

endmodule

// File: rtl/nibble_sequencer.sv
// Program buffer plus player that resets the stack core and replays nibbles with core fetch/exec timing.
// Optional NIBBLE_SEQ_LOOP_EN restarts the program without a core reset while loop is held.
module nibble_sequencer
   import nibble_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH      = SEQ_DEPTH,
   parameter int unsigned AW         = SEQ_AW,
   parameter int unsigned RST_CYCLES = SEQ_RST_CYCLES
)(
   input  logic              clk,
   input  logic              rst,
   nibble_sequencer_if.slave bus
);

   localparam int unsigned CW      = ($clog2(RST_CYCLES) > 2) ? $clog2(RST_CYCLES) : 2;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [3:0]    mem_q [DEPTH];
   seq_state_e    state_q;
   logic [AW:0]   prog_len_q, prog_len_d;
   logic [AW:0]   pc_q, pc_inc, pc_next;
   logic [CW-1:0] cnt_q;
   logic          has_op_q;
   logic          cpu_rst_q, done_q, busy_q, ready_q;
   logic [3:0]    inbits_q;
   logic          xfer, last_op, loop_go;
   logic [3:0]    fetch_nib;
   logic [1:0]    fetch_len;
   logic          fetch_has;

   assign xfer      = bus.load_valid && ready_q;
   assign fetch_nib = mem_q[pc_q[AW-1:0]];
   assign pc_inc    = pc_q + (AW+1)'(1);
   assign pc_next   = pc_q + (AW+1)'(has_op_q);
   assign last_op   = (pc_next >= prog_len_q);
`ifdef NIBBLE_SEQ_LOOP_EN
   assign loop_go   = bus.loop;
`else
   assign loop_go   = 1'b0;
`endif

   nibble_sequencer_op_timing u_op_timing (
      .op_i          (fetch_nib),
      .exec_len_o    (fetch_len),
      .has_operand_o (fetch_has)
   );

   // Loads only ever land while idle; clear beats a same-cycle transfer.
   always_comb begin
      prog_len_d = prog_len_q;
      if (state_q == SEQ_IDLE) begin
         if (bus.clear) prog_len_d = '0;
         else if (xfer) prog_len_d = prog_len_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (xfer && !bus.clear) mem_q[prog_len_q[AW-1:0]] <= bus.load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SEQ_IDLE;
         prog_len_q <= '0;
         pc_q       <= '0;
         cnt_q      <= '0;
         has_op_q   <= 1'b0;
         cpu_rst_q  <= 1'b0;
         inbits_q   <= 4'd0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         prog_len_q <= prog_len_d;
         done_q     <= 1'b0;
         case (state_q)
            SEQ_IDLE: begin
               ready_q <= (prog_len_d < DEPTH_L);
               if (bus.start && (prog_len_d != '0)) begin
                  pc_q      <= '0;
                  cnt_q     <= CW'(RST_CYCLES - 1);
                  cpu_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
                  state_q   <= SEQ_CRST;
               end
            end
            SEQ_CRST: begin
               if (cnt_q == '0) begin
                  cpu_rst_q <= 1'b0;
                  inbits_q  <= fetch_nib;
                  state_q   <= SEQ_FETCH;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            SEQ_FETCH: begin
               has_op_q <= fetch_has;
               pc_q     <= pc_inc;
               cnt_q    <= CW'(fetch_len - 2'd1);
               inbits_q <= (fetch_has && (pc_inc < prog_len_q)) ? mem_q[pc_inc[AW-1:0]] : 4'd0;
               state_q  <= SEQ_EXEC;
            end
            SEQ_EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else if (!last_op) begin
                  pc_q     <= pc_next;
                  inbits_q <= mem_q[pc_next[AW-1:0]];
                  state_q  <= SEQ_FETCH;
               end else if (loop_go) begin
                  pc_q     <= '0;
                  inbits_q <= mem_q[0];
                  done_q   <= 1'b1;
                  state_q  <= SEQ_FETCH;
               end else begin
                  pc_q     <= pc_next;
                  inbits_q <= 4'd0;
                  done_q   <= 1'b1;
                  state_q  <= SEQ_DONE;
               end
            end
            SEQ_DONE: begin
               busy_q  <= 1'b0;
               ready_q <= (prog_len_q < DEPTH_L);
               state_q <= SEQ_IDLE;
            end
            default: state_q <= SEQ_IDLE;
         endcase
      end
   end

   assign bus.load_ready = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.prog_len   = prog_len_q;
   assign bus.cpu_rst    = cpu_rst_q;
   assign bus.cpu_inbits = inbits_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Bench for nibble_sequencer: random programs replayed against a trace model built from the opcode rules.
module tb_nibble_sequencer;

   typedef struct packed {
      logic       rst;
      logic [3:0] inb;
      logic       done;
      logic       busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] prog_m [$];
   exp_t       tr_q [$];
   exp_t       exp_q [$];
   exp_t       cur;

   nibble_sequencer_if #(.AW(4)) bus ();

   nibble_sequencer u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic r, input logic [3:0] i, input logic d, input logic b);
      return {r, i, d, b};
   endfunction

   function automatic int exec_len(input int op);
      if (op == 9) return 3;
      if (op inside {1, 2, 5, 6, 7, 8}) return 2;
      return 1;
   endfunction

   function automatic bit has_opnd(input int op);
      return op inside {1, 6, 7, 8};
   endfunction

   // Expected per-cycle core drive for one run of prog_m, starting the cycle after start is taken.
   task automatic build_trace();
      int pc;
      int len;
      int opnd;
      tr_q.delete();
      repeat (2) tr_q.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1));
      pc  = 0;
      len = prog_m.size();
      while (pc < len) begin
         tr_q.push_back(mk(1'b0, prog_m[pc], 1'b0, 1'b1));
         opnd = (has_opnd(prog_m[pc]) && (pc + 1 < len)) ? int'(prog_m[pc+1]) : 0;
         repeat (exec_len(prog_m[pc])) tr_q.push_back(mk(1'b0, 4'(opnd), 1'b0, 1'b1));
         pc += has_opnd(prog_m[pc]) ? 2 : 1;
      end
      tr_q.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1));
      tr_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0));
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         chk("cpu_rst", bus.cpu_rst, cur.rst);
         chk("cpu_inbits", bus.cpu_inbits, cur.inb);
         chk("done", bus.done, cur.done);
         chk("busy", bus.busy, cur.busy);
      end
   end

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic load_nib(input logic [3:0] d);
      @(negedge clk);
      chk("load_ready", bus.load_ready, (prog_m.size() < 16) ? 1 : 0);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      @(posedge clk);
      #1;
      bus.load_valid = 1'b0;
      if (prog_m.size() < 16) prog_m.push_back(d);
   endtask

   task automatic clear_buf();
      @(negedge clk);
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      prog_m.delete();
   endtask

   task automatic check_len(input string name);
      @(negedge clk);
      chk(name, bus.prog_len, prog_m.size());
   endtask

   task automatic run_prog();
      build_trace();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      foreach (tr_q[i]) exp_q.push_back(tr_q[i]);
      drain();
   endtask

   initial begin
      logic [3:0] pin_in [5];
      int n;
      pin_in = '{4'd1, 4'd7, 4'd7, 4'd4, 4'd0};
      bus.clear      = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = 4'd0;
      bus.start      = 1'b0;
`ifdef NIBBLE_SEQ_LOOP_EN
      bus.loop       = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cpu_rst", bus.cpu_rst, 0);
      chk("rst_inbits", bus.cpu_inbits, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_prog_len", bus.prog_len, 0);
      chk("rst_load_ready", bus.load_ready, 1);
      rst = 1'b0;

      // Program 1,7,4: model pinned against hand-derived drive sequence.
      load_nib(4'd1); load_nib(4'd7); load_nib(4'd4);
      check_len("len_174");
      build_trace();
      chk("pin_174_size", tr_q.size(), 9);
      chk("pin_174_crst0", tr_q[0].rst, 1);
      chk("pin_174_crst1", tr_q[1].rst, 1);
      for (int i = 0; i < 5; i++) chk("pin_174_inbits", tr_q[2+i].inb, pin_in[i]);
      chk("pin_174_done", tr_q[7].done, 1);
      run_prog();
      check_len("len_174_after");

      clear_buf();
      load_nib(4'd9);
      build_trace();
      chk("pin_mult_size", tr_q.size(), 8);
      chk("pin_mult_fetch", tr_q[2].inb, 9);
      chk("pin_mult_done", tr_q[6].done, 1);
      run_prog();

      clear_buf();
      load_nib(4'd3); load_nib(4'd1);
      build_trace();
      chk("pin_31_size", tr_q.size(), 9);
      chk("pin_31_fetch2", tr_q[4].inb, 1);
      run_prog();

      // Full buffer: 17th load dropped, then run and clear.
      clear_buf();
      for (int i = 0; i < 16; i++) load_nib(4'($urandom_range(0, 15)));
      load_nib(4'd5);
      check_len("len_full");
      chk("full_ready", bus.load_ready, 0);
      run_prog();
      chk("full_ready_after_run", bus.load_ready, 0);
      clear_buf();
      check_len("len_cleared");
      chk("cleared_ready", bus.load_ready, 1);

      // Clear and load in the same cycle: clear wins.
      load_nib(4'd2);
      @(negedge clk);
      bus.clear = 1'b1; bus.load_valid = 1'b1; bus.load_data = 4'd6;
      @(posedge clk);
      #1;
      bus.clear = 1'b0; bus.load_valid = 1'b0;
      prog_m.delete();
      check_len("len_clear_wins");

      for (int r = 0; r < 8; r++) begin
         clear_buf();
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) load_nib(4'($urandom_range(0, 15)));
         check_len("len_rand");
         run_prog();
      end

      // Async reset during EXEC of PUSH in a 4-op program.
      clear_buf();
      load_nib(4'd1); load_nib(4'd7); load_nib(4'd4); load_nib(4'd9);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midrun_exec_inbits", bus.cpu_inbits, 7);
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_cpu_rst", bus.cpu_rst, 0);
      chk("arst_inbits", bus.cpu_inbits, 0);
      chk("arst_prog_len", bus.prog_len, 0);
      @(negedge clk);
      rst = 1'b0;
      prog_m.delete();
      @(negedge clk);
      bus.start = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("empty_start_busy", bus.busy, 0);
      chk("empty_start_cpu_rst", bus.cpu_rst, 0);
      bus.start = 1'b0;

`ifdef NIBBLE_SEQ_LOOP_EN
      clear_buf();
      load_nib(4'd3);
      bus.loop = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      exp_q.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd3, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd3, 1'b1, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0));
      repeat (5) @(negedge clk);
      bus.loop = 1'b0;
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
